// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises 8-bit DDS samples into 16-bit SPI frames for a DAC.
// Frame layout is {4'b0011, sample, 4'b0000}, sent MSB first with dac_sclk idle low.
// The data bit is updated on the sys_clk cycle where dac_sclk falls, so it is
// stable across every rising edge.
// Optional feature: define DAC_SPI_SKIP_DUP_EN to drop frames whose sample
// equals the last transmitted one. The handshake still completes.
module dac_spi_tx #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       sample_ready,
  output logic       dac_cs_n,
  output logic       dac_sclk,
  output logic       dac_din,
  output logic       frame_done
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned BIT_W = 4;
  localparam int unsigned SH_W  = 15;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(15);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [BIT_W-1:0]  bit_idx, bit_nx;
  logic [SH_W-1:0]   sh, sh_nx;
  logic              ready_nx, cs_n_nx, sclk_nx, din_nx, done_nx;
  logic              accept_c;
  logic              skip_c;
  logic [15:0]       frame_c;

  assign accept_c = sample_valid && sample_ready;
  assign frame_c  = {4'b0011, sample_in, 4'b0000};

`ifdef DAC_SPI_SKIP_DUP_EN
  logic [7:0] last, last_nx;
  logic       last_vld, last_vld_nx;

  assign skip_c = last_vld && (sample_in == last);

  // Remember the last transmitted sample; the valid flag forces the first post-reset send.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last     <= '0;
      last_vld <= 1'b0;
    end else begin
      last     <= last_nx;
      last_vld <= last_vld_nx;
    end
  end

  // Capture every accepted sample (duplicates leave the value unchanged anyway).
  always_comb begin
    last_nx     = last;
    last_vld_nx = last_vld;
    if (accept_c) begin
      last_nx     = sample_in;
      last_vld_nx = 1'b1;
    end
  end
`else
  assign skip_c = 1'b0;
`endif

  // State, counters, shift register and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      sh           <= '0;
      sample_ready <= 1'b0;
      dac_cs_n     <= 1'b1;
      dac_sclk     <= 1'b0;
      dac_din      <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      bit_idx      <= bit_nx;
      sh           <= sh_nx;
      sample_ready <= ready_nx;
      dac_cs_n     <= cs_n_nx;
      dac_sclk     <= sclk_nx;
      dac_din      <= din_nx;
      frame_done   <= done_nx;
    end
  end

  // Next-state and next-output logic; the half-period counter restarts at every phase change.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CNT_W'(1);
    bit_nx   = bit_idx;
    sh_nx    = sh;
    cs_n_nx  = dac_cs_n;
    sclk_nx  = dac_sclk;
    din_nx   = dac_din;
    done_nx  = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (accept_c && !skip_c) begin
          state_nx = SETUP;
          sh_nx    = frame_c[SH_W-1:0];
          din_nx   = frame_c[15];
          cs_n_nx  = 1'b0;
          bit_nx   = '0;
        end
      end
      SETUP: begin
        if (cnt == CNT_LAST) begin
          state_nx = SHIFT;
          cnt_nx   = '0;
        end
      end
      SHIFT: begin
        if (cnt == CNT_LAST) begin
          cnt_nx = '0;
          if (!dac_sclk) begin
            sclk_nx = 1'b1;
          end else begin
            sclk_nx = 1'b0;
            if (bit_idx == BIT_LAST) begin
              state_nx = HOLD;
            end else begin
              bit_nx = bit_idx + BIT_W'(1);
              din_nx = sh[SH_W-1];
              sh_nx  = {sh[SH_W-2:0], 1'b0};
            end
          end
        end
      end
      HOLD: begin
        if (cnt == CNT_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          cs_n_nx  = 1'b1;
          din_nx   = 1'b0;
          done_nx  = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase

    // Ready only while resting in IDLE; the frame_done cycle itself is not ready.
    ready_nx = (state == IDLE) && (state_nx == IDLE);
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: two DUT instances (CLK_DIV 4 and 1) driven with directed and
// random samples. A line-level monitor decodes the SPI pins and compares them
// against frames predicted from each accepted handshake.
module tb_dac_spi_tx;

  localparam int unsigned DIV0 = 4;
  localparam int unsigned DIV1 = 1;

  logic            sys_clk   = 1'b0;
  logic            sys_rst_n = 1'b0;
  logic [1:0][7:0] smp;
  logic [1:0]      vld;
  logic [1:0]      rdy, cs, sck, din, fd;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  dac_spi_tx #(.CLK_DIV(DIV0)) u_dut4 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sample_in(smp[0]), .sample_valid(vld[0]),
    .sample_ready(rdy[0]), .dac_cs_n(cs[0]), .dac_sclk(sck[0]), .dac_din(din[0]),
    .frame_done(fd[0]));

  dac_spi_tx #(.CLK_DIV(DIV1)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sample_in(smp[1]), .sample_valid(vld[1]),
    .sample_ready(rdy[1]), .dac_cs_n(cs[1]), .dac_sclk(sck[1]), .dac_din(din[1]),
    .frame_done(fd[1]));

  // Single comparison point: counts every check, reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int div_of(input int g);
    return (g == 0) ? int'(DIV0) : int'(DIV1);
  endfunction

  // Reference model / monitor state, one slot per instance.
  logic [15:0] expq [2][$];
  int          accq [2][$];
  logic [1:0]  pcs  = 2'b11;
  logic [1:0]  psck = 2'b00;
  logic [1:0]  pdin = 2'b00;
  int          low_run [2];
  int          hi_run  [2];
  int          cs_low  [2];
  int          rises   [2];
  int          rrun    [2];
  int          frames  [2];
  bit          first   [2];
  bit          rr_act  [2];
  logic [15:0] cap     [2];
`ifdef DAC_SPI_SKIP_DUP_EN
  logic [7:0]  last     [2];
  bit          last_vld [2];
`endif

  initial begin
    for (int g = 0; g < 2; g++) begin
      frames[g] = 0; rises[g] = 0; cap[g] = '0; rr_act[g] = 0; first[g] = 0;
      low_run[g] = 0; hi_run[g] = 0; cs_low[g] = 0; rrun[g] = 0;
    end
  end

  // Decode pins on the falling edge and compare against the predicted frames.
  always @(negedge sys_clk) begin
    for (int g = 0; g < 2; g++) begin
      int d;
      bit dup;
      d = div_of(g);
      if (!sys_rst_n) begin
        expq[g].delete();
        accq[g].delete();
        rr_act[g] = 0;
        rises[g]  = 0;
`ifdef DAC_SPI_SKIP_DUP_EN
        last_vld[g] = 0;
`endif
      end else begin
        chk("frame_done", 32'(fd[g]), 32'(cs[g] && !pcs[g]));
        if (cs[g]) chk("idle_lines", 32'({sck[g], din[g]}), 32'(2'b00));
        else begin
          chk("ready_in_frame", 32'(rdy[g]), 32'(0));
          if (!pcs[g] && (din[g] != pdin[g]))
            chk("din_on_fall", 32'({psck[g], sck[g]}), 32'(2'b10));
        end
        if (pcs[g] && !cs[g]) begin
          if (expq[g].size() == 0) chk("unexpected_frame", 32'(1), 32'(0));
          cap[g] = '0; rises[g] = 0; first[g] = 1;
          low_run[g] = 0; hi_run[g] = 0; cs_low[g] = 0;
        end
        if (!cs[g]) begin
          if (!psck[g] && sck[g]) begin
            chk("sclk_low_len", 32'(low_run[g]), 32'(first[g] ? 2 * d : d));
            cap[g] = {cap[g][14:0], din[g]};
            rises[g]++;
            first[g]  = 0;
            hi_run[g] = 0;
          end
          if (psck[g] && !sck[g]) begin
            chk("sclk_high_len", 32'(hi_run[g]), 32'(d));
            low_run[g] = 0;
          end
          if (sck[g]) hi_run[g]++; else low_run[g]++;
          cs_low[g]++;
        end
        if (!pcs[g] && cs[g] && (expq[g].size() > 0)) begin
          chk("frame_word", 32'(cap[g]), 32'(expq[g].pop_front()));
          chk("accept_to_cs_rise", 32'(cyc - accq[g].pop_front()), 32'(1 + 34 * d));
          chk("sclk_rises", 32'(rises[g]), 32'(16));
          chk("cs_low_len", 32'(cs_low[g]), 32'(34 * d));
          frames[g]++;
        end
        if (rr_act[g]) begin
          if (rdy[g]) begin
            chk("ready_low_len", 32'(rrun[g]), 32'(34 * d + 1));
            rr_act[g] = 0;
          end else rrun[g]++;
        end
        if (vld[g] && rdy[g]) begin
          dup = 0;
`ifdef DAC_SPI_SKIP_DUP_EN
          dup = last_vld[g] && (smp[g] == last[g]);
          last[g]     = smp[g];
          last_vld[g] = 1;
`endif
          if (!dup) begin
            expq[g].push_back({4'b0011, smp[g], 4'b0000});
            accq[g].push_back(cyc);
            rr_act[g] = 1;
            rrun[g]   = 0;
          end
        end
      end
      pcs[g]  = cs[g];
      psck[g] = sck[g];
      pdin[g] = din[g];
    end
  end

  // Offer one sample and hold valid until the handshake completes.
  task automatic offer(input int g, input logic [7:0] s);
    bit ok;
    ok = 0;
    smp[g] = s;
    vld[g] = 1'b1;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge sys_clk);
      if (rdy[g]) ok = 1;
    end
    @(posedge sys_clk); #1;
    vld[g] = 1'b0;
    if (!ok) chk("accept_timeout", 32'(0), 32'(1));
  endtask

  // Wait until the instance is idle and ready again.
  task automatic wait_idle(input int g);
    bit ok;
    ok = 0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge sys_clk);
      if (cs[g] && rdy[g]) ok = 1;
    end
    @(posedge sys_clk); #1;
    if (!ok) chk("idle_timeout", 32'(0), 32'(1));
  endtask

  // Scramble sample_in and pulse valid while the frame is in flight.
  task automatic noise(input int g);
    for (int k = 0; k < 8; k++) begin
      smp[g] = 8'($urandom);
      vld[g] = 1'($urandom_range(0, 1));
      @(posedge sys_clk); #1;
    end
    vld[g] = 1'b0;
  endtask

  initial begin
    int f0;
    int exp_dup;
    bit hit;
    vld = '0;
    smp = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_cs_n", 32'(cs), 32'(2'b11));
    chk("rst_sclk", 32'(sck), 32'(2'b00));
    chk("rst_din", 32'(din), 32'(2'b00));
    chk("rst_done", 32'(fd), 32'(2'b00));
    chk("rst_ready", 32'(rdy), 32'(2'b00));
    #3 sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    chk("ready_after_rst", 32'(rdy), 32'(2'b11));

    // Single-cycle valid, sample A5, CLK_DIV 4.
    offer(0, 8'hA5);
    wait_idle(0);
    chk("a5_frames", 32'(frames[0]), 32'(1));
    chk("a5_word", 32'(cap[0]), 32'(16'h3A50));

    // CLK_DIV 1, sample 81.
    offer(1, 8'h81);
    wait_idle(1);
    chk("x81_word", 32'(cap[1]), 32'(16'h3810));

    // Valid held high across two back-to-back samples.
    for (int g = 0; g < 2; g++) begin
      f0 = frames[g];
      offer(g, 8'h00);
      offer(g, 8'hFF);
      wait_idle(g);
      chk("held_valid_frames", 32'(frames[g] - f0), 32'(2));
      chk("held_valid_word", 32'(cap[g]), 32'(16'h3FF0));
    end

    // Duplicate sample sequence 40, 40, 41.
`ifdef DAC_SPI_SKIP_DUP_EN
    exp_dup = 2;
`else
    exp_dup = 3;
`endif
    f0 = frames[1];
    offer(1, 8'h40); wait_idle(1);
    offer(1, 8'h40); wait_idle(1);
    offer(1, 8'h41); wait_idle(1);
    chk("dup_frames", 32'(frames[1] - f0), 32'(exp_dup));
    chk("dup_last_word", 32'(cap[1]), 32'(16'h3410));

    // Random samples with mid-frame input noise.
    for (int k = 0; k < 30; k++) begin
      int g;
      g = int'($urandom_range(0, 1));
      offer(g, 8'($urandom));
      noise(g);
      repeat ($urandom_range(0, 4)) @(posedge sys_clk);
      #1;
    end
    wait_idle(0);
    wait_idle(1);

    // Reset in the middle of a frame, after the 7th sclk rise.
    f0 = frames[0];
    offer(0, 8'($urandom));
    hit = 0;
    for (int n = 0; n < 500 && !hit; n++) begin
      @(negedge sys_clk);
      if (rises[0] >= 7 && !cs[0]) hit = 1;
    end
    if (!hit) chk("sclk7_timeout", 32'(0), 32'(1));
    @(posedge sys_clk); #2;
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_cs_n", 32'(cs[0]), 32'(1));
    chk("midrst_sclk", 32'(sck[0]), 32'(0));
    chk("midrst_din", 32'(din[0]), 32'(0));
    chk("midrst_ready", 32'(rdy[0]), 32'(0));
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk); #1;
    sys_rst_n = 1'b1;
    chk("rel_ready_low", 32'(rdy[0]), 32'(0));
    for (int n = 0; n < 20; n++) begin
      @(negedge sys_clk);
      chk("post_rst_sclk", 32'(sck[0]), 32'(0));
      chk("post_rst_cs_n", 32'(cs[0]), 32'(1));
    end
    chk("post_rst_ready", 32'(rdy[0]), 32'(1));
    chk("no_resume", 32'(frames[0] - f0), 32'(0));
    @(posedge sys_clk); #1;
    offer(0, 8'h5A);
    wait_idle(0);
    chk("post_rst_frames", 32'(frames[0] - f0), 32'(1));
    chk("post_rst_word", 32'(cap[0]), 32'(16'h35A0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dac_spi_tx.md
DAC_SPI_TX -- requirements
Module: dac_spi_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, sys_clk cycles per dac_sclk half-period; legal range 1..255.
REQ-002 SHALL have port sys_clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port sys_rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port sample_in  input  8  unsigned waveform sample from the DDS ROM output.
REQ-005 SHALL have port sample_valid  input  1  sample_in is offered this cycle.
REQ-006 SHALL have port sample_ready  output  1  block accepts a sample this cycle.
REQ-007 SHALL have port dac_cs_n  output  1  DAC chip select, active low.
REQ-008 SHALL have port dac_sclk  output  1  DAC serial clock, idle low.
REQ-009 SHALL have port dac_din  output  1  DAC serial data, MSB first.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse at frame end.

Function
REQ-011 SHALL implement FSM states IDLE, SETUP, SHIFT, HOLD; all outputs registered.
REQ-012 sample_ready SHALL be 1 only in IDLE; accept = sample_valid && sample_ready.
REQ-013 On accept: load 16-bit frame {4'b0011, sample_in, 4'b0000}, next state SETUP; dac_cs_n low and dac_din = frame[15] from the next cycle.
REQ-014 SETUP SHALL last CLK_DIV cycles, dac_sclk low, then go to SHIFT.
REQ-015 SHIFT SHALL produce 16 dac_sclk periods, each CLK_DIV cycles low then CLK_DIV cycles high; dac_din changes only on the cycle dac_sclk falls (shift left, next bit), stable across every rising edge.
REQ-016 After the 16th high half-period, dac_sclk SHALL return low and the FSM go to HOLD.
REQ-017 HOLD SHALL last CLK_DIV cycles with dac_cs_n low, then dac_cs_n high, dac_din low, frame_done = 1 for exactly one cycle, state IDLE.
REQ-018 Accept-to-dac_cs_n-rise SHALL be 1 + 34*CLK_DIV cycles (137 at default); next accept possible the cycle after dac_cs_n rises.
REQ-019 sample_valid while not ready SHALL be ignored; sample_in changes mid-frame SHALL not affect the frame in flight.
REQ-020 Half-period counter SHALL be 8 bits, reload to 0 on every state/phase change, never wrap within a phase.
REQ-021 CLK_DIV = 1 SHALL yield dac_sclk = sys_clk/2 with identical sequencing.

Reset
REQ-022 On sys_rst_n low (any time, including mid-frame): state IDLE, dac_cs_n = 1, dac_sclk = 0, dac_din = 0, frame_done = 0, sample_ready = 0 during reset, 1 from the first clock after release; shift register, counters and last-sample register cleared to 0.
REQ-023 A frame interrupted by reset SHALL not resume; the first post-reset frame starts only on a new accept.

Configuration
REQ-024 Macro DAC_SPI_SKIP_DUP_EN: when defined, an accepted sample equal to the last transmitted sample completes the handshake but sends no frame (dac_cs_n stays high, no frame_done, ready stays 1); first sample after reset always transmits.
REQ-025 Without DAC_SPI_SKIP_DUP_EN every accepted sample SHALL produce a full frame; last-sample register absent.

Verification
REQ-026 CLK_DIV=4, sample 8'hA5 valid for 1 cycle -> din bits 0011_1010_0101_0000 captured on 16 sclk rising edges, cs_n low 136 cycles, one frame_done pulse.
REQ-027 sample_valid held high with 8'h00 then 8'hFF -> exactly one frame per accept, ready low 137 cycles per frame, no sample dropped or duplicated.
REQ-028 sys_rst_n asserted after 7th sclk rise -> same cycle cs_n=1, sclk=0, din=0; after release no sclk activity until next accept.
REQ-029 CLK_DIV=1, sample 8'h81 -> sclk period 2 cycles, frame 0011_1000_0001_0000, accept-to-cs_n-rise 35 cycles.
REQ-030 DAC_SPI_SKIP_DUP_EN defined, samples 8'h40, 8'h40, 8'h41 -> two frames (0x40, 0x41), second 0x40 accepted with cs_n held high; macro undefined -> three frames.
